// File: rtl/vote_pkg.sv
// Shared constants and state encoding for the vote result read-out path.
// Tally and total widths are sized so that four full tallies cannot overflow the total.
package vote_pkg;

    localparam int NUM_CAND = 4;
    localparam int CNT_W    = 8;
    localparam int TOTAL_W  = 10;
    localparam int IDX_W    = 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [TOTAL_W-1:0] zext_total(input logic [CNT_W-1:0] v);
        return TOTAL_W'(v);
    endfunction

endpackage

// File: rtl/vote_scan_unit.sv
// Sequential max/tie/total datapath: consumes one snapshot tally per step.
// The lowest index keeps the win on equal counts because only a strict increase moves the winner.
import vote_pkg::*;

module vote_scan_unit (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_step,
    input  logic [IDX_W-1:0]   i_idx,
    input  logic [CNT_W-1:0]   i_votes,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_tie,
    output logic [TOTAL_W-1:0] o_total
);

    logic [CNT_W-1:0]   r_max;
    logic [IDX_W-1:0]   r_winner;
    logic               r_tie;
    logic [TOTAL_W-1:0] r_total;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max    <= '0;
            r_winner <= '0;
            r_tie    <= 1'b0;
            r_total  <= '0;
        end else if (i_clear) begin
            r_max    <= '0;
            r_winner <= '0;
            r_tie    <= 1'b0;
            r_total  <= '0;
        end else if (i_step) begin
            r_total <= r_total + zext_total(i_votes);
            if (i_idx == '0) begin
                r_max    <= i_votes;
                r_winner <= '0;
            end else if (i_votes > r_max) begin
                r_max    <= i_votes;
                r_winner <= i_idx;
                r_tie    <= 1'b0;
            end else if (i_votes == r_max) begin
                r_tie <= 1'b1;
            end
        end
    end

    assign o_winner = r_winner;
    assign o_tie    = r_tie;
    assign o_total  = r_total;

endmodule

// File: rtl/vote_result_reader.sv
// Display-mode read-out: snapshots the tallies, scans for winner/tie/total, then streams
// one (candidate, votes) record per candidate over valid/ready, ending with a done pulse.
import vote_pkg::*;

module vote_result_reader (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               start,
    input  logic [CNT_W-1:0]   cand1Votes,
    input  logic [CNT_W-1:0]   cand2Votes,
    input  logic [CNT_W-1:0]   cand3Votes,
    input  logic [CNT_W-1:0]   cand4Votes,
    output logic               busy,
    output logic [IDX_W-1:0]   winner,
    output logic               tie,
    output logic [TOTAL_W-1:0] total,
    output logic               winner_valid,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [IDX_W-1:0]   rec_cand,
    output logic [CNT_W-1:0]   rec_votes,
    output logic               done,
    output state_t             dbg_state
);

    // Record handshake: a record transfers on a rising edge where rec_valid and rec_ready are
    // both high; while rec_valid is high and rec_ready is low, rec_cand/rec_votes do not change.

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_snap [NUM_CAND];
    logic               r_busy;
    logic               r_winner_valid;
    logic               r_rec_valid;
    logic [IDX_W-1:0]   r_rec_cand;
    logic [CNT_W-1:0]   r_rec_votes;
    logic               r_done;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   w_idx_inc;
    logic               w_winner_valid_nxt;
    logic               w_rec_valid_nxt;
    logic [IDX_W-1:0]   w_rec_cand_nxt;
    logic [CNT_W-1:0]   w_rec_votes_nxt;
    logic               w_done_nxt;
    logic               w_snap_en;
    logic               w_clear;
    logic               w_step;
    logic [CNT_W-1:0]   w_live [NUM_CAND];

    assign w_live[0] = cand1Votes;
    assign w_live[1] = cand2Votes;
    assign w_live[2] = cand3Votes;
    assign w_live[3] = cand4Votes;
    assign w_idx_inc = r_idx + IDX_W'(1);

    always_comb begin
        w_state_nxt        = r_state;
        w_idx_nxt          = r_idx;
        w_winner_valid_nxt = r_winner_valid;
        w_rec_valid_nxt    = r_rec_valid;
        w_rec_cand_nxt     = r_rec_cand;
        w_rec_votes_nxt    = r_rec_votes;
        w_done_nxt         = 1'b0;
        w_snap_en          = 1'b0;
        w_clear            = 1'b0;
        w_step             = 1'b0;

        // Leaving display mode abandons the read-out, including any record still on offer.
        if (r_state != ST_IDLE && !mode) begin
            w_state_nxt        = ST_IDLE;
            w_winner_valid_nxt = 1'b0;
            w_rec_valid_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!mode) begin
                        w_winner_valid_nxt = 1'b0;
                    end else if (start) begin
                        w_state_nxt        = ST_SCAN;
                        w_snap_en          = 1'b1;
                        w_clear            = 1'b1;
                        w_idx_nxt          = '0;
                        w_winner_valid_nxt = 1'b0;
                    end
                end
                ST_SCAN: begin
                    w_step = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt        = ST_EMIT;
                        w_idx_nxt          = '0;
                        w_winner_valid_nxt = 1'b1;
                        w_rec_valid_nxt    = 1'b1;
                        w_rec_cand_nxt     = '0;
                        w_rec_votes_nxt    = r_snap[0];
                    end else begin
                        w_idx_nxt = w_idx_inc;
                    end
                end
                ST_EMIT: begin
                    if (r_rec_valid && rec_ready) begin
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt     = ST_DONE;
                            w_rec_valid_nxt = 1'b0;
                            w_done_nxt      = 1'b1;
                        end else begin
                            w_idx_nxt       = w_idx_inc;
                            w_rec_cand_nxt  = w_idx_inc;
                            w_rec_votes_nxt = r_snap[w_idx_inc];
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_busy         <= 1'b0;
            r_winner_valid <= 1'b0;
            r_rec_valid    <= 1'b0;
            r_rec_cand     <= '0;
            r_rec_votes    <= '0;
            r_done         <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_winner_valid <= w_winner_valid_nxt;
            r_rec_valid    <= w_rec_valid_nxt;
            r_rec_cand     <= w_rec_cand_nxt;
            r_rec_votes    <= w_rec_votes_nxt;
            r_done         <= w_done_nxt;
            if (w_snap_en) begin
                for (int i = 0; i < NUM_CAND; i++) begin
                    r_snap[i] <= w_live[i];
                end
            end
        end
    end

    vote_scan_unit u_scan (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_step   (w_step),
        .i_idx    (r_idx),
        .i_votes  (r_snap[r_idx]),
        .o_winner (winner),
        .o_tie    (tie),
        .o_total  (total)
    );

    assign busy         = r_busy;
    assign winner_valid = r_winner_valid;
    assign rec_valid    = r_rec_valid;
    assign rec_cand     = r_rec_cand;
    assign rec_votes    = r_rec_votes;
    assign done         = r_done;
    assign dbg_state    = r_state;

endmodule

// File: doc/vote_result_reader.md
Name: vote_result_reader

Overview:
- Read-out side of the vote counter. In display mode it snapshots the four candidate tallies and scans them one per cycle.
- It produces the winner index, a tie flag and the 10-bit total.
- It then streams one (candidate, votes) record per candidate over a valid/ready handshake to the display/announce logic.
- Sits between voteCounter outputs and the result/display path of votingMachine.

Parameters:
- NUM_CAND, 4, number of candidates (index width 2).
- CNT_W, 8, width of each tally.
- TOTAL_W, 10, width of total; must hold NUM_CAND*(2^CNT_W-1) = 1020.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  1 = display mode, 0 = voting mode.
- start  input  1  read-out request; sampled only in IDLE with mode=1.
- cand1Votes..cand4Votes  input  CNT_W each  live tallies from voteCounter.
- busy  output  1  high in any state other than IDLE.
- winner  output  2  index of the winning candidate (0 = cand1).
- tie  output  1  at least one other candidate equals the max.
- total  output  TOTAL_W  sum of the four snapshot tallies.
- winner_valid  output  1  winner/tie/total are valid.
- rec_valid  output  1  record present on rec_cand/rec_votes.
- rec_ready  input  1  consumer accepts the record.
- rec_cand  output  2  candidate index of the current record.
- rec_votes  output  CNT_W  snapshot tally of rec_cand.
- done  output  1  one-cycle pulse after the last record is accepted.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE.
  - All outputs 0.
  - Snapshot registers, max, idx, total all 0.
- State machine:
  - IDLE -> SCAN on an edge where start=1 and mode=1. On that edge: snapshot all four tallies, idx=0, total=0, tie=0, winner_valid=0.
  - SCAN: one candidate per cycle, idx 0..3.
    - total += snap[idx], zero-extended to TOTAL_W; no overflow is possible.
    - idx==0: max=snap[0], winner=0.
    - snap[idx] > max: max=snap[idx], winner=idx, tie=0.
    - snap[idx] == max: tie=1, winner unchanged, so the lowest index wins ties.
    - On the idx==3 edge: go to EMIT with idx=0 and set winner_valid=1.
  - EMIT:
    - rec_valid=1, rec_cand=idx, rec_votes=snap[idx].
    - On rec_valid&&rec_ready, idx advances. Without acceptance, rec_cand/rec_votes are held stable.
    - Acceptance at idx==3 -> DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. winner/tie/total/winner_valid hold.
- Latency:
  - Start sampled at edge T; SCAN occupies edges T+1..T+4.
  - winner_valid and rec_valid are high after edge T+4.
  - With rec_ready held high, the 4 records take 4 consecutive cycles and done is high after edge T+8.
- Boundaries:
  - start while busy, or with mode=0: ignored.
  - Tallies changing after the snapshot edge do not affect results.
  - All counts equal (including all zero): winner=0, tie=1.
  - mode=0 in any non-IDLE state: abort to IDLE on the next edge; rec_valid, winner_valid, busy, done cleared. A record pending at abort is not accepted.
  - mode=0 in IDLE: winner_valid cleared.
  - New accepted start: winner_valid drops until the new scan completes.
  - rst asserted mid-operation: immediate return to reset state.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package/header vote_pkg holds:
  - NUM_CAND, CNT_W, TOTAL_W, IDX_W=2.
  - State encoding IDLE/SCAN/EMIT/DONE.
- One sub-module, vote_scan_unit: sequential max/tie/accumulate datapath driven by clear/step/idx from the FSM.
- Record mux and handshake stay in the top.

Test Plan:
- Basic: counts 10,20,5,3, start, rec_ready=1 -> winner=1, tie=0, total=38; records (0,10),(1,20),(2,5),(3,3) on 4 consecutive cycles; single done pulse.
- Ties: 7,9,9,2 -> winner=1, tie=1, total=27. All 255 -> winner=0, tie=1, total=1020. All 0 -> winner=0, tie=1, total=0.
- Backpressure: rec_ready low 3 cycles while rec_cand=2 -> rec_cand=2, rec_votes stable; no record skipped or duplicated; done only after record 3 is accepted.
- Snapshot/ignore: change cand1Votes 10->99 and pulse start again during SCAN -> results still reflect 10; no restart.
- Abort: drop mode during EMIT at idx=1 -> next cycle IDLE, rec_valid=0, winner_valid=0, busy=0, no done.
- Reset: assert rst mid-SCAN -> all outputs 0 without waiting for a clock edge; a new start after release gives correct results.
